regfile_write_arbiter: RTL
==========================

Name: regfile_write_arbiter

Overview:
- Shares the single register-file write port between NUM_REQ requesters using a round-robin grant.
- Registers the winning write (enable, register index, data) onto the write port with one cycle of latency.
- Contains a scrub sequencer that writes zero to every register address on command, used at boot and on error recovery.
- Sits between the pipeline writeback sources and the register-file write port.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ADDR_W, 5, register index width
DATA_W, 32, write data width

Ports:
clk  input  1  clock, all state updates on rising edge
clr_n  input  1  synchronous active-low reset, sampled on rising clk
req  input  NUM_REQ  per-requester write request
req_addr  input  NUM_REQ*ADDR_W  packed indexes; requester i occupies [i*ADDR_W +: ADDR_W]
req_data  input  NUM_REQ*DATA_W  packed data; requester i occupies [i*DATA_W +: DATA_W]
gnt  output  NUM_REQ  one-hot grant, combinational from req, pointer and state
scrub_start  input  1  single-cycle pulse that requests a full zero sweep
scrub_busy  output  1  high while the sweep runs
scrub_done  output  1  one-cycle pulse after the last sweep write is issued
wr_en  output  1  register-file write enable
wr_addr  output  ADDR_W  register-file write index
wr_data  output  DATA_W  register-file write data

Behaviour:
- Reset (clr_n=0 at an edge): state IDLE, rr_ptr=0, wr_en=0, wr_addr=0, wr_data=0, scrub_busy=0, scrub_done=0, sweep counter=0.
- Reset takes effect at the sampling edge regardless of state; asserting it mid-sweep aborts the sweep and does not produce scrub_done.
- gnt: in IDLE with req!=0, exactly one bit is set. It selects the first set req bit searching rr_ptr, rr_ptr+1, ..., wrapping modulo NUM_REQ. gnt=0 when req=0, in SCRUB, or while clr_n=0.
- Handshake: a transfer occurs at an edge where req[i]&gnt[i]=1. The requester holds req, addr and data stable until that edge and may drop req or present a new request afterwards.
- Write latency is 1 cycle: on the edge after a transfer, wr_en=1 with the granted addr and data. With no transfer, wr_en=0 and wr_addr/wr_data hold their last values.
- Pointer update: after a transfer by requester i, rr_ptr = (i+1) mod NUM_REQ. Otherwise rr_ptr is unchanged.
- Fairness: a continuously asserted req is granted within NUM_REQ cycles.
- States:
  IDLE: arbitrate. If scrub_start=1, go to SCRUB with counter=0. scrub_start wins over req in the same cycle: gnt=0 that cycle and no transfer occurs.
  SCRUB: each cycle drive wr_en=1 (registered), wr_addr=counter, wr_data=0, then counter+1. The state is entered with counter=0 and the first sweep write appears on the edge after entry. After the write with counter=2^ADDR_W-1, go to DONE.
  DONE: scrub_done=1 for one cycle, then return to IDLE.
- scrub_busy=1 in SCRUB, and only in SCRUB.
- scrub_start is ignored in SCRUB and DONE. Requesters stall (gnt=0) for 2^ADDR_W+1 cycles in total.
- Counter is ADDR_W+1 bits wide so the terminal compare does not wrap.

Optional Feature:
- Macro: WARB_ZERO_FILTER_EN.
- Defined: a granted write with addr=0 completes the handshake (gnt and rr_ptr behave normally) but produces wr_en=0 on the following cycle. The scrub sweep still writes address 0.
- Undefined: writes to address 0 pass through unfiltered.

Test Plan:
- Reset then idle: clr_n=0 for 2 cycles, then req=0 -> gnt=0, wr_en=0, wr_addr=0, wr_data=0, scrub_busy=0.
- Single requester: req=4'b0100, addr2=5'd7, data2=32'hDEADBEEF -> gnt=4'b0100 that cycle; next cycle wr_en=1, wr_addr=7, wr_data=DEADBEEF; rr_ptr=3.
- Round robin: req=4'b1111 held for 8 cycles from reset -> grant order 0,1,2,3,0,1,2,3, one wr_en pulse per cycle carrying each requester's data.
- Scrub: pulse scrub_start with req=4'b0001 asserted in the same cycle -> gnt=0 that cycle; scrub_busy high for 32 cycles with wr_addr sweeping 0..31 and wr_data=0; scrub_done pulses once; requester 0 is granted the cycle after scrub_done.
- Reset mid-scrub: assert clr_n=0 at sweep address 10 -> next cycle state IDLE, wr_en=0, scrub_busy=0, and scrub_done never pulses.
- WARB_ZERO_FILTER_EN defined: requester 1 writes addr 0, data 32'h1 -> gnt[1]=1, next cycle wr_en=0, rr_ptr=2. With the macro undefined, the same stimulus gives wr_en=1, wr_addr=0.

Source files
------------

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter for the shared register-file write port, with a zero-fill scrub sweep.
// Optional build macro WARB_ZERO_FILTER_EN suppresses granted writes to register index 0.
module regfile_write_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ADDR_W  = 5,
    parameter int unsigned DATA_W  = 32
) (
    input  logic                        clk,
    input  logic                        clr_n,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]          gnt,
    input  logic                        scrub_start,
    output logic                        scrub_busy,
    output logic                        scrub_done,
    output logic                        wr_en,
    output logic [ADDR_W-1:0]           wr_addr,
    output logic [DATA_W-1:0]           wr_data
);

    localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = {1'b0, {ADDR_W{1'b1}}};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCRUB,
        ST_DONE
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [PTR_W-1:0]   rr_ptr;
    logic [PTR_W-1:0]   gnt_idx;
    logic [PTR_W-1:0]   cand;
    logic               found;
    logic [NUM_REQ-1:0] rr_gnt;
    logic               arb_en;
    logic               xfer;
    logic               wr_keep;
    logic [CNT_W-1:0]   sweep_cnt;
    logic [ADDR_W-1:0]  sel_addr;
    logic [DATA_W-1:0]  sel_data;

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (scrub_start) state_nxt = ST_SCRUB;
            ST_SCRUB: if (sweep_cnt == LAST_CNT) state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // scrub_start in IDLE pre-empts arbitration for that cycle
    always_comb begin
        arb_en     = clr_n && (state == ST_IDLE) && !scrub_start;
        scrub_busy = (state == ST_SCRUB);
        scrub_done = (state == ST_DONE);
        gnt        = arb_en ? rr_gnt : '0;
    end

    // Search starts at rr_ptr and wraps modulo NUM_REQ
    always_comb begin
        rr_gnt  = '0;
        gnt_idx = '0;
        cand    = '0;
        found   = 1'b0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = PTR_W'((32'(rr_ptr) + k) % NUM_REQ);
            if (!found && req[cand]) begin
                rr_gnt[cand] = 1'b1;
                gnt_idx      = cand;
                found        = 1'b1;
            end
        end
    end

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            sel_addr = sel_addr | ({ADDR_W{rr_gnt[i]}} & req_addr[i*ADDR_W +: ADDR_W]);
            sel_data = sel_data | ({DATA_W{rr_gnt[i]}} & req_data[i*DATA_W +: DATA_W]);
        end
    end

    assign xfer = |gnt;

`ifdef WARB_ZERO_FILTER_EN
    assign wr_keep = (sel_addr != '0);
`else
    assign wr_keep = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            rr_ptr <= '0;
        end else if (xfer) begin
            rr_ptr <= (gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            sweep_cnt <= '0;
        end else if (state == ST_SCRUB) begin
            sweep_cnt <= sweep_cnt + 1'b1;
        end else begin
            sweep_cnt <= '0;
        end
    end

    // A filtered write still completes the handshake but leaves the port idle
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else if (state == ST_SCRUB) begin
            wr_en   <= 1'b1;
            wr_addr <= sweep_cnt[ADDR_W-1:0];
            wr_data <= '0;
        end else if (xfer && wr_keep) begin
            wr_en   <= 1'b1;
            wr_addr <= sel_addr;
            wr_data <= sel_data;
        end else begin
            wr_en   <= 1'b0;
        end
    end

endmodule
